lsu_nbload_tracker: RTL and testbench

LSU_NBLOAD_TRACKER -- requirements
Module: lsu_nbload_tracker

---
 rtl/lsu_nbload_tracker.sv | 136 +++++++++++++
 tb/tb_lsu_nbload_tracker.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_nbload_tracker.sv
// lsu_nbload_tracker
//   Tracks outstanding non-blocking loads. Each entry holds a valid bit,
//   a stale bit and the destination register. A load is allocated a tag,
//   its data return frees the tag, and a non-stale return produces a
//   registered writeback request one cycle later. Newer loads to the same
//   register, or a pipeline flush, mark older entries stale so that their
//   data is discarded when it eventually comes back.
//
// Ports
//   clk, rst_l            clock, asynchronous active-low reset
//   alloc_valid/alloc_rd  allocation request and its destination register
//   alloc_ready/alloc_tag free entry exists / lowest free tag
//   rtn_valid/rtn_tag     load data return and its tag
//   flush                 mark all outstanding loads stale
//   cam_rd/cam_hit        lookup of a pending, non-stale load to a register
//   wb_valid/wb_rd/wb_tag registered writeback request
//   spurious_rtn          registered pulse for a return to a free tag
//   busy_cnt              number of valid entries
module lsu_nbload_tracker #(
  parameter int DEPTH = 4,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             alloc_valid,
  input  logic [4:0]       alloc_rd,
  output logic             alloc_ready,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             rtn_valid,
  input  logic [TAG_W-1:0] rtn_tag,
  input  logic             flush,
  input  logic [4:0]       cam_rd,
  output logic             cam_hit,
  output logic             wb_valid,
  output logic [4:0]       wb_rd,
  output logic [TAG_W-1:0] wb_tag,
  output logic             spurious_rtn,
  output logic [TAG_W:0]   busy_cnt
);

  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [DEPTH-1:0]      stale_q, stale_d;
  logic [DEPTH-1:0][4:0] rd_q, rd_d;

  logic             wb_valid_q, wb_valid_d;
  logic [4:0]       wb_rd_q, wb_rd_d;
  logic [TAG_W-1:0] wb_tag_q, wb_tag_d;
  logic             spurious_q, spurious_d;

  logic allocFire;
  logic rtnHit;

  // Occupancy is a popcount of the valid bits, so it can never drift out
  // of range. The free-tag search walks downward so the lowest free index
  // wins; a just-returned entry is still valid here, which prevents
  // same-cycle reuse of its tag.
  always_comb begin
    busy_cnt  = '0;
    alloc_tag = '0;
    cam_hit   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_cnt = busy_cnt + (TAG_W+1)'(valid_q[i]);
    end
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!valid_q[i]) alloc_tag = TAG_W'(i);
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && !stale_q[i] && rd_q[i] == cam_rd && cam_rd != 5'd0)
        cam_hit = 1'b1;
    end
  end

  assign alloc_ready = (busy_cnt != (TAG_W+1)'(DEPTH));
  assign allocFire   = alloc_valid && alloc_ready;
  assign rtnHit      = rtn_valid && valid_q[rtn_tag];

  // Entry update. Flush and supersede only touch entries that are already
  // valid; the freshly allocated entry is written last so a same-cycle
  // flush cannot mark it stale. The allocated slot is never the returning
  // slot because allocation only picks entries that are currently free.
  always_comb begin
    valid_d = valid_q;
    stale_d = stale_q;
    rd_d    = rd_q;
    if (flush) stale_d = stale_q | valid_q;
    if (rtnHit) valid_d[rtn_tag] = 1'b0;
    if (allocFire) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && rd_q[i] == alloc_rd) stale_d[i] = 1'b1;
      end
      valid_d[alloc_tag] = 1'b1;
      stale_d[alloc_tag] = (alloc_rd == 5'd0);
      rd_d[alloc_tag]    = alloc_rd;
    end
  end

  // Writeback and spurious-return flags are computed from pre-edge entry
  // state, so a return racing with a flush still writes back.
  always_comb begin
    wb_valid_d = rtnHit && !stale_q[rtn_tag];
    wb_rd_d    = wb_rd_q;
    wb_tag_d   = wb_tag_q;
    if (rtnHit && !stale_q[rtn_tag]) begin
      wb_rd_d  = rd_q[rtn_tag];
      wb_tag_d = rtn_tag;
    end
    spurious_d = rtn_valid && !valid_q[rtn_tag];
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      valid_q    <= '0;
      stale_q    <= '0;
      rd_q       <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_tag_q   <= '0;
      spurious_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      stale_q    <= stale_d;
      rd_q       <= rd_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_tag_q   <= wb_tag_d;
      spurious_q <= spurious_d;
    end
  end

  assign wb_valid     = wb_valid_q;
  assign wb_rd        = wb_rd_q;
  assign wb_tag       = wb_tag_q;
  assign spurious_rtn = spurious_q;

endmodule

// File: tb/tb_lsu_nbload_tracker.sv
module tb_lsu_nbload_tracker;
  localparam int DEPTH = 4;
  localparam int TAG_W = 2;

  logic             clk;
  logic             rst_l;
  logic             alloc_valid;
  logic [4:0]       alloc_rd;
  logic             alloc_ready;
  logic [TAG_W-1:0] alloc_tag;
  logic             rtn_valid;
  logic [TAG_W-1:0] rtn_tag;
  logic             flush;
  logic [4:0]       cam_rd;
  logic             cam_hit;
  logic             wb_valid;
  logic [4:0]       wb_rd;
  logic [TAG_W-1:0] wb_tag;
  logic             spurious_rtn;
  logic [TAG_W:0]   busy_cnt;

  int checkCount = 0;
  int passCount  = 0;

  lsu_nbload_tracker #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_l(rst_l),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .rtn_valid(rtn_valid), .rtn_tag(rtn_tag), .flush(flush),
    .cam_rd(cam_rd), .cam_hit(cam_hit),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_tag(wb_tag),
    .spurious_rtn(spurious_rtn), .busy_cnt(busy_cnt)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
  endtask

  // Drive one cycle's worth of inputs and let combinational outputs settle.
  task automatic applyStimulus(input logic av, input logic [4:0] ard,
                               input logic rv, input logic [TAG_W-1:0] rtag,
                               input logic fl, input logic [4:0] crd);
    alloc_valid = av;
    alloc_rd    = ard;
    rtn_valid   = rv;
    rtn_tag     = rtag;
    flush       = fl;
    cam_rd      = crd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [4:0] crd);
    applyStimulus(1'b0, 5'd0, 1'b0, '0, 1'b0, crd);
  endtask

  initial begin
    rst_l = 1'b0;
    idle(5'd0);
    #10;
    checkOutput("rst_busy", 32'(busy_cnt), 0);
    checkOutput("rst_ready", 32'(alloc_ready), 1);
    checkOutput("rst_tag", 32'(alloc_tag), 0);
    checkOutput("rst_wbv", 32'(wb_valid), 0);
    checkOutput("rst_spur", 32'(spurious_rtn), 0);
    checkOutput("rst_cam", 32'(cam_hit), 0);
    rst_l = 1'b1;
    tick();

    // Fill: rd 1..4 take tags 0..3
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 5'(i + 1), 1'b0, '0, 1'b0, 5'd0);
      checkOutput($sformatf("fill_tag%0d", i), 32'(alloc_tag), i);
      tick();
    end
    idle(5'd3);
    checkOutput("fill_busy", 32'(busy_cnt), 4);
    checkOutput("fill_ready", 32'(alloc_ready), 0);
    checkOutput("fill_cam3", 32'(cam_hit), 1);
    applyStimulus(1'b1, 5'd9, 1'b0, '0, 1'b0, 5'd0);
    tick();
    checkOutput("fill_5th_ignored", 32'(busy_cnt), 4);

    // Full: return tag 1 with an alloc in the same cycle -> alloc ignored
    applyStimulus(1'b1, 5'd9, 1'b1, 2'd1, 1'b0, 5'd9);
    tick();
    checkOutput("bnd_busy", 32'(busy_cnt), 3);
    checkOutput("bnd_wbv", 32'(wb_valid), 1);
    checkOutput("bnd_wbrd", 32'(wb_rd), 2);
    checkOutput("bnd_cam9", 32'(cam_hit), 0);
    applyStimulus(1'b1, 5'd10, 1'b0, '0, 1'b0, 5'd0);
    checkOutput("bnd_ready", 32'(alloc_ready), 1);
    checkOutput("bnd_tag1", 32'(alloc_tag), 1);
    tick();
    checkOutput("bnd_busy4", 32'(busy_cnt), 4);
    // Drain in tag order: rd 1, 10, 3, 4
    for (int i = 0; i < 4; i++) begin
      logic [4:0] expRd [4];
      expRd = '{5'd1, 5'd10, 5'd3, 5'd4};
      applyStimulus(1'b0, 5'd0, 1'b1, TAG_W'(i), 1'b0, 5'd0);
      tick();
      checkOutput($sformatf("drain_wbv%0d", i), 32'(wb_valid), 1);
      checkOutput($sformatf("drain_wbrd%0d", i), 32'(wb_rd), 32'(expRd[i]));
      checkOutput($sformatf("drain_wbtag%0d", i), 32'(wb_tag), i);
    end
    idle(5'd0);
    checkOutput("drain_busy", 32'(busy_cnt), 0);

    // Writeback latency
    applyStimulus(1'b1, 5'd5, 1'b0, '0, 1'b0, 5'd0);
    tick();
    idle(5'd0);
    checkOutput("wb_busy1", 32'(busy_cnt), 1);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b1, 2'd0, 1'b0, 5'd0);
    checkOutput("wb_pre", 32'(wb_valid), 0);
    tick();
    idle(5'd0);
    checkOutput("wb_valid", 32'(wb_valid), 1);
    checkOutput("wb_rd5", 32'(wb_rd), 5);
    checkOutput("wb_tag0", 32'(wb_tag), 0);
    checkOutput("wb_busy0", 32'(busy_cnt), 0);
    tick();
    checkOutput("wb_pulse", 32'(wb_valid), 0);

    // Same-cycle alloc and return
    applyStimulus(1'b1, 5'd6, 1'b0, '0, 1'b0, 5'd0);
    tick();
    applyStimulus(1'b1, 5'd8, 1'b1, 2'd0, 1'b0, 5'd0);
    checkOutput("ar_tag", 32'(alloc_tag), 1);
    tick();
    idle(5'd8);
    checkOutput("ar_busy", 32'(busy_cnt), 1);
    checkOutput("ar_wbrd", 32'(wb_rd), 6);
    checkOutput("ar_cam8", 32'(cam_hit), 1);
    applyStimulus(1'b0, 5'd0, 1'b1, 2'd1, 1'b0, 5'd0);
    tick();
    checkOutput("ar_wbrd8", 32'(wb_rd), 8);
    checkOutput("ar_busy0", 32'(busy_cnt), 0);

    // Supersede
    applyStimulus(1'b1, 5'd7, 1'b0, '0, 1'b0, 5'd7);
    tick();
    applyStimulus(1'b1, 5'd7, 1'b0, '0, 1'b0, 5'd7);
    checkOutput("sup_cam_a", 32'(cam_hit), 1);
    checkOutput("sup_tag1", 32'(alloc_tag), 1);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b1, 2'd0, 1'b0, 5'd7);
    checkOutput("sup_cam_b", 32'(cam_hit), 1);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b1, 2'd1, 1'b0, 5'd7);
    checkOutput("sup_nowb", 32'(wb_valid), 0);
    checkOutput("sup_cam_c", 32'(cam_hit), 1);
    tick();
    idle(5'd7);
    checkOutput("sup_wbv", 32'(wb_valid), 1);
    checkOutput("sup_wbrd", 32'(wb_rd), 7);
    checkOutput("sup_wbtag", 32'(wb_tag), 1);
    checkOutput("sup_cam_d", 32'(cam_hit), 0);

    // Flush with three outstanding plus a same-cycle alloc
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 5'(11 + i), 1'b0, '0, 1'b0, 5'd0);
      tick();
    end
    applyStimulus(1'b1, 5'd14, 1'b0, '0, 1'b1, 5'd12);
    checkOutput("fl_cam_pre", 32'(cam_hit), 1);
    tick();
    idle(5'd12);
    checkOutput("fl_cam12", 32'(cam_hit), 0);
    idle(5'd14);
    checkOutput("fl_cam14", 32'(cam_hit), 1);
    checkOutput("fl_busy4", 32'(busy_cnt), 4);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 5'd0, 1'b1, TAG_W'(i), 1'b0, 5'd0);
      tick();
      checkOutput($sformatf("fl_nowb%0d", i), 32'(wb_valid), 0);
    end
    applyStimulus(1'b0, 5'd0, 1'b1, 2'd3, 1'b1, 5'd0);
    tick();
    idle(5'd0);
    checkOutput("fl_rtn_wbv", 32'(wb_valid), 1);
    checkOutput("fl_rtn_wbrd", 32'(wb_rd), 14);
    checkOutput("fl_busy0", 32'(busy_cnt), 0);

    // Spurious return while empty
    applyStimulus(1'b0, 5'd0, 1'b1, 2'd2, 1'b0, 5'd0);
    tick();
    idle(5'd0);
    checkOutput("sp_pulse", 32'(spurious_rtn), 1);
    checkOutput("sp_busy", 32'(busy_cnt), 0);
    tick();
    checkOutput("sp_clear", 32'(spurious_rtn), 0);

    // Alloc to r0 is born stale
    applyStimulus(1'b1, 5'd0, 1'b0, '0, 1'b0, 5'd0);
    tick();
    idle(5'd0);
    checkOutput("r0_cam", 32'(cam_hit), 0);
    checkOutput("r0_busy", 32'(busy_cnt), 1);
    applyStimulus(1'b0, 5'd0, 1'b1, 2'd0, 1'b0, 5'd0);
    tick();
    checkOutput("r0_nowb", 32'(wb_valid), 0);
    checkOutput("r0_nospur", 32'(spurious_rtn), 0);
    checkOutput("r0_busy0", 32'(busy_cnt), 0);

    // Asynchronous reset mid-traffic
    applyStimulus(1'b1, 5'd1, 1'b0, '0, 1'b0, 5'd0);
    tick();
    applyStimulus(1'b1, 5'd2, 1'b0, '0, 1'b0, 5'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b1, 2'd0, 1'b0, 5'd2);
    tick();
    checkOutput("mr_wbv_pre", 32'(wb_valid), 1);
    #2;
    rst_l = 1'b0;
    #1;
    checkOutput("mr_wbv", 32'(wb_valid), 0);
    checkOutput("mr_wbrd", 32'(wb_rd), 0);
    checkOutput("mr_busy", 32'(busy_cnt), 0);
    checkOutput("mr_ready", 32'(alloc_ready), 1);
    checkOutput("mr_tag", 32'(alloc_tag), 0);
    checkOutput("mr_cam", 32'(cam_hit), 0);
    #3;
    rst_l = 1'b1;
    applyStimulus(1'b0, 5'd0, 1'b1, 2'd1, 1'b0, 5'd0);
    tick();
    idle(5'd0);
    checkOutput("mr_spur", 32'(spurious_rtn), 1);
    checkOutput("mr_nowb", 32'(wb_valid), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
